// File: rtl/gb_cpu_sequencer.sv
// Instruction sequencer: opcode fetch, microcode decode, M-cycle/T-state
// stepping, CB prefix, HALT and interrupt dispatch.
module gb_cpu_sequencer #(
    parameter int unsigned TSTATES_PER_MCYCLE = 4,
    parameter int unsigned IRQ_MCYCLES        = 5,
    parameter logic [7:0]  CB_OPCODE          = 8'hCB
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        pc_inc,
    output logic [7:0]  opcode,
    input  logic [59:0] ctrl_word,
    output logic [59:0] exec_ctrl,
    output logic        exec_en,
    output logic [2:0]  mcycle,
    output logic [1:0]  tstate,
    output logic        cb_mode,
    input  logic        irq_pending,
    input  logic        irq_wake,
    output logic        irq_take,
    output logic        halted,
    output logic        instr_done
);

    localparam logic [1:0] T_LAST     = 2'(TSTATES_PER_MCYCLE - 1);
    localparam logic [2:0] M_IRQ_LAST = 3'(IRQ_MCYCLES - 1);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT,
        S_IRQ
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic       run;
    logic [2:0] cnt;
    logic [2:0] m_last;
    logic       t_wrap;
    logic       exec_last;
    logic       irq_last;
    logic       fetch_ack;
    logic       is_cb;
    logic       halt_exit;

    // A zero M-cycle count is treated as a single M-cycle
    assign cnt       = exec_ctrl[59:57];
    assign m_last    = (cnt == 3'd0) ? 3'd0 : cnt - 3'd1;
    assign t_wrap    = (tstate == T_LAST);
    assign exec_last = (state == S_EXEC) && t_wrap
                     && (mcycle == m_last);
    assign irq_last  = (state == S_IRQ) && t_wrap
                     && (mcycle == M_IRQ_LAST);
    assign fetch_ack = (state == S_FETCH) && run && mem_ack;
    assign is_cb     = (opcode == CB_OPCODE) && !cb_mode;
    assign halt_exit = (state == S_HALT) && (state_nx != S_HALT);

    always_comb begin
        state_nx   = state;
        mem_req    = 1'b0;
        exec_en    = 1'b0;
        halted     = 1'b0;
        irq_take   = 1'b0;
        instr_done = 1'b0;
        unique case (state)
            S_FETCH: begin
                mem_req = run;
                if (fetch_ack)
                    state_nx = S_DECODE;
            end
            S_DECODE: begin
                if (is_cb)
                    state_nx = S_FETCH;
                else if (ctrl_word[56])
                    state_nx = S_HALT;
                else
                    state_nx = S_EXEC;
            end
            S_EXEC: begin
                exec_en = 1'b1;
                if (exec_last) begin
                    instr_done = 1'b1;
                    state_nx   = irq_pending ? S_IRQ : S_FETCH;
                end
            end
            S_HALT: begin
                halted = 1'b1;
                if (irq_pending)
                    state_nx = S_IRQ;
                else if (irq_wake)
                    state_nx = S_FETCH;
            end
            S_IRQ: begin
                irq_take = (mcycle == 3'd0) && (tstate == 2'd0);
                if (irq_last)
                    state_nx = S_FETCH;
            end
            default: state_nx = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_FETCH;
        else
            state <= state_nx;
    end

    // run keeps mem_req low until the first clock after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run    <= 1'b0;
            pc_inc <= 1'b0;
            opcode <= 8'h00;
        end else begin
            run    <= 1'b1;
            pc_inc <= fetch_ack;
            if (fetch_ack)
                opcode <= mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exec_ctrl <= '0;
            cb_mode   <= 1'b0;
        end else begin
            if (state == S_DECODE) begin
                if (is_cb)
                    cb_mode <= 1'b1;
                else
                    exec_ctrl <= ctrl_word;
            end
            if (exec_last || halt_exit || state == S_IRQ)
                cb_mode <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcycle <= 3'd0;
            tstate <= 2'd0;
        end else if (state == S_EXEC || state == S_IRQ) begin
            if (t_wrap) begin
                tstate <= 2'd0;
                if (exec_last || irq_last)
                    mcycle <= 3'd0;
                else
                    mcycle <= mcycle + 3'd1;
            end else begin
                tstate <= tstate + 2'd1;
            end
        end else begin
            mcycle <= 3'd0;
            tstate <= 2'd0;
        end
    end

endmodule

// File: tb/tb_gb_cpu_sequencer.sv
// Directed bench for gb_cpu_sequencer: fetch, CB prefix, multi M-cycle,
// HALT, interrupt dispatch and asynchronous reset mid-instruction.
module tb_gb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        pc_inc;
    logic [7:0]  opcode;
    logic [59:0] ctrl_word;
    logic [59:0] exec_ctrl;
    logic        exec_en;
    logic [2:0]  mcycle;
    logic [1:0]  tstate;
    logic        cb_mode;
    logic        irq_pending;
    logic        irq_wake;
    logic        irq_take;
    logic        halted;
    logic        instr_done;

    int checks = 0;
    int errors = 0;

    gb_cpu_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_req     (mem_req),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .pc_inc      (pc_inc),
        .opcode      (opcode),
        .ctrl_word   (ctrl_word),
        .exec_ctrl   (exec_ctrl),
        .exec_en     (exec_en),
        .mcycle      (mcycle),
        .tstate      (tstate),
        .cb_mode     (cb_mode),
        .irq_pending (irq_pending),
        .irq_wake    (irq_wake),
        .irq_take    (irq_take),
        .halted      (halted),
        .instr_done  (instr_done)
    );

    always #5 clk = ~clk;

    function automatic logic [59:0] cw(input logic [2:0] n,
                                       input logic h,
                                       input logic [55:0] p);
        return {n, h, p};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one byte on a clock where the sequencer is in FETCH
    task automatic fetch(input logic [7:0] b, input logic [59:0] w);
        chk("fetch_req", 64'(mem_req), 64'd1);
        ctrl_word = w;
        mem_ack   = 1'b1;
        mem_rdata = b;
        step();
        mem_ack = 1'b0;
        chk("pc_inc", 64'(pc_inc), 64'd1);
        chk("opcode", 64'(opcode), 64'(b));
        chk("req_dec", 64'(mem_req), 64'd0);
    endtask

    // Starts on the first EXEC clock, ends one clock past the last
    task automatic exec_check(input int n);
        logic [4:0] e;
        for (int i = 0; i < 4 * n; i++) begin
            e = {3'(i / 4), 2'(i % 4)};
            chk("exec_en", 64'(exec_en), 64'd1);
            chk("mt", 64'({mcycle, tstate}), 64'(e));
            chk("done", 64'(instr_done), 64'(i == 4 * n - 1));
            chk("req_ex", 64'(mem_req), 64'd0);
            step();
        end
        chk("done_off", 64'(instr_done), 64'd0);
        chk("exec_off", 64'(exec_en), 64'd0);
    endtask

    // Starts on the first IRQ clock, ends one clock past the last
    task automatic irq_check();
        logic [4:0] e;
        for (int i = 0; i < 20; i++) begin
            e = {3'(i / 4), 2'(i % 4)};
            chk("irq_take", 64'(irq_take), 64'(i == 0));
            chk("irq_mt", 64'({mcycle, tstate}), 64'(e));
            chk("irq_req", 64'(mem_req), 64'd0);
            chk("irq_en", 64'(exec_en), 64'd0);
            chk("irq_cb", 64'(cb_mode), 64'd0);
            step();
        end
        chk("irq_fetch", 64'(mem_req), 64'd1);
        chk("irq_take0", 64'(irq_take), 64'd0);
    endtask

    localparam logic [55:0] P1 = 56'hA5_5A00_1234_5678;
    localparam logic [55:0] P2 = 56'h0F_F0C3_3C96_6901;
    localparam logic [55:0] P3 = 56'h12_3456_789A_BCDE;

    initial begin
        rst_n       = 1'b0;
        mem_ack     = 1'b0;
        mem_rdata   = 8'h00;
        ctrl_word   = '0;
        irq_pending = 1'b0;
        irq_wake    = 1'b0;
        step();
        step();
        chk("rst_flags",
            64'({mem_req, pc_inc, exec_en, cb_mode,
                 irq_take, halted, instr_done}), 64'd0);
        chk("rst_op", 64'(opcode), 64'd0);
        chk("rst_ctrl", 64'(exec_ctrl), 64'd0);
        chk("rst_mt", 64'({mcycle, tstate}), 64'd0);

        // Basic instruction, ack on the 3rd clock after release
        rst_n = 1'b1;
        chk("req_pre", 64'(mem_req), 64'd0);
        step();
        chk("req_c1", 64'(mem_req), 64'd1);
        step();
        chk("req_c2", 64'(mem_req), 64'd1);
        chk("pc_c2", 64'(pc_inc), 64'd0);
        fetch(8'h00, cw(3'd1, 1'b0, P1));
        chk("dec_en", 64'(exec_en), 64'd0);
        step();
        chk("pc_off", 64'(pc_inc), 64'd0);
        chk("ctrl1", 64'(exec_ctrl), 64'(cw(3'd1, 1'b0, P1)));
        exec_check(1);
        chk("back_fetch", 64'(mem_req), 64'd1);

        // CB prefix then 0x37, mem_ack held off for one FETCH clock
        step();
        chk("wait_req", 64'(mem_req), 64'd1);
        fetch(8'hCB, cw(3'd2, 1'b0, P2));
        chk("cb_pre", 64'(cb_mode), 64'd0);
        step();
        chk("cb_set", 64'(cb_mode), 64'd1);
        chk("cb_ctrl", 64'(exec_ctrl), 64'(cw(3'd1, 1'b0, P1)));
        chk("cb_fetch", 64'(mem_req), 64'd1);
        chk("cb_pc0", 64'(pc_inc), 64'd0);
        fetch(8'h37, cw(3'd2, 1'b0, P2));
        step();
        chk("cb_ctrl2", 64'(exec_ctrl), 64'(cw(3'd2, 1'b0, P2)));
        chk("cb_hold", 64'(cb_mode), 64'd1);
        exec_check(2);
        chk("cb_clr", 64'(cb_mode), 64'd0);

        // Three M-cycles
        fetch(8'h3E, cw(3'd3, 1'b0, P3));
        step();
        exec_check(3);

        // Zero count behaves as one M-cycle
        fetch(8'h01, cw(3'd0, 1'b0, P2));
        step();
        chk("ctrl0", 64'(exec_ctrl), 64'(cw(3'd0, 1'b0, P2)));
        exec_check(1);

        // HALT, ignore stray mem_ack, leave on irq_wake
        fetch(8'h76, cw(3'd1, 1'b1, P1));
        step();
        mem_ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("halted", 64'(halted), 64'd1);
            chk("halt_req", 64'(mem_req), 64'd0);
            chk("halt_en", 64'(exec_en), 64'd0);
            chk("halt_pc", 64'(pc_inc), 64'd0);
            chk("halt_mt", 64'({mcycle, tstate}), 64'd0);
            step();
        end
        mem_ack  = 1'b0;
        irq_wake = 1'b1;
        step();
        irq_wake = 1'b0;
        chk("wake_halt", 64'(halted), 64'd0);
        chk("wake_req", 64'(mem_req), 64'd1);
        chk("wake_take", 64'(irq_take), 64'd0);

        // irq_pending high from FETCH on: taken only at instruction end
        irq_pending = 1'b1;
        fetch(8'h00, cw(3'd1, 1'b0, P3));
        step();
        exec_check(1);
        chk("ie_halt", 64'(halted), 64'd0);
        irq_check();

        // HALT exited by a pending interrupt
        fetch(8'h76, cw(3'd1, 1'b1, P2));
        irq_pending = 1'b0;
        step();
        chk("h2_halted", 64'(halted), 64'd1);
        step();
        chk("h2_hold", 64'(halted), 64'd1);
        irq_pending = 1'b1;
        step();
        irq_pending = 1'b0;
        chk("h2_exit", 64'(halted), 64'd0);
        irq_check();

        // Asynchronous reset in the middle of EXEC
        fetch(8'h10, cw(3'd2, 1'b0, P1));
        step();
        for (int i = 0; i < 6; i++)
            step();
        chk("mid_mt", 64'({mcycle, tstate}), 64'({3'd1, 2'd2}));
        chk("mid_en", 64'(exec_en), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_flags",
            64'({mem_req, pc_inc, exec_en, cb_mode,
                 irq_take, halted, instr_done}), 64'd0);
        chk("ar_op", 64'(opcode), 64'd0);
        chk("ar_ctrl", 64'(exec_ctrl), 64'd0);
        chk("ar_mt", 64'({mcycle, tstate}), 64'd0);
        step();
        rst_n = 1'b1;
        chk("ar_req0", 64'(mem_req), 64'd0);
        step();
        fetch(8'h00, cw(3'd1, 1'b0, P2));
        step();
        exec_check(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
